// File: rtl/mem_arb_pkg.sv
// Shared constants for the three-port memory arbiter.
// Requester indices and vector width used by every file of the block.
package mem_arb_pkg;

  localparam int NUM_REQ   = 3;
  localparam int REQ_VIDEO = 0;
  localparam int REQ_CPU   = 1;
  localparam int REQ_IO    = 2;

  typedef logic [NUM_REQ-1:0] req_vec_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side bundle of the memory port arbiter.
// slave = arbiter view, master = requesters plus memory.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  req_vec_t                    req;
  req_vec_t                    we;
  logic [NUM_REQ*ADDR_W-1:0]   addr;
  logic [NUM_REQ*DATA_W-1:0]   wdata;
  req_vec_t                    gnt;
  req_vec_t                    rvalid;
  logic [DATA_W-1:0]           rdata;

  logic                        mem_en;
  logic                        mem_we;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic [DATA_W-1:0]           mem_rdata;

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    input  mem_rdata,
    output gnt,
    output rvalid,
    output rdata,
    output mem_en,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    output mem_rdata,
    input  gnt,
    input  rvalid,
    input  rdata,
    input  mem_en,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

endinterface

// File: rtl/arb_rr2.sv
// Two-way round-robin pick between the CPU and IO requesters.
// ptr_q=0 prefers req[0]; the loser of every grant becomes preferred.
module arb_rr2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0] && (!req[1] || !ptr_q)) begin
        gnt[0] = 1'b1;
      end else if (req[1]) begin
        gnt[1] = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (gnt[0]) begin
      ptr_d = 1'b1;
    end else if (gnt[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: video has fixed priority, CPU/IO share
// round-robin; all memory-side outputs and grants are registered.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  req_vec_t          elig;
  req_vec_t          win;
  req_vec_t          gnt_d;
  req_vec_t          gnt_q;
  req_vec_t          rvalid_d;
  req_vec_t          rvalid_q;
  logic [1:0]        rr_gnt;
  logic              mem_en_d;
  logic              mem_en_q;
  logic              mem_we_d;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_d;
  logic [DATA_W-1:0] mem_wdata_q;

  // A port granted this cycle sits out the next decision.
  assign elig = bus.req & ~gnt_q;

  arb_rr2 u_rr (
    .clk   (clk),
    .reset (reset),
    .en    (!elig[REQ_VIDEO]),
    .req   ({elig[REQ_IO], elig[REQ_CPU]}),
    .gnt   (rr_gnt)
  );

  always_comb begin
    win            = '0;
    win[REQ_VIDEO] = elig[REQ_VIDEO];
    win[REQ_CPU]   = rr_gnt[0];
    win[REQ_IO]    = rr_gnt[1];
  end

  always_comb begin
    gnt_d       = win;
    mem_en_d    = |win;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (1'b1)
      win[REQ_VIDEO]: begin
        mem_we_d    = bus.we[REQ_VIDEO];
        mem_addr_d  = bus.addr[REQ_VIDEO*ADDR_W +: ADDR_W];
        mem_wdata_d = bus.wdata[REQ_VIDEO*DATA_W +: DATA_W];
      end
      win[REQ_CPU]: begin
        mem_we_d    = bus.we[REQ_CPU];
        mem_addr_d  = bus.addr[REQ_CPU*ADDR_W +: ADDR_W];
        mem_wdata_d = bus.wdata[REQ_CPU*DATA_W +: DATA_W];
      end
      win[REQ_IO]: begin
        mem_we_d    = bus.we[REQ_IO];
        mem_addr_d  = bus.addr[REQ_IO*ADDR_W +: ADDR_W];
        mem_wdata_d = bus.wdata[REQ_IO*DATA_W +: DATA_W];
      end
      default: begin
      end
    endcase
    // The memory returns read data one cycle after the grant cycle.
    rvalid_d = (mem_en_q && !mem_we_q) ? gnt_q : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_q       <= '0;
      rvalid_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = bus.mem_rdata;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
